// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter requester: width constants,
// the requester FSM state type and one-hot helper functions.
package arb_pkg;

  localparam int N    = 8;
  localparam int IDXW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Index of the set bit; only meaningful when the input is one-hot.
  function automatic logic [IDXW-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | IDXW'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Combinational one-hot to index encoder, the inverse of the arbiter's
// index-to-one-hot grant output. Reports whether any bit is set and
// whether the input is a legal one-hot code.
module onehot_encoder
  import arb_pkg::*;
(
  input  logic [N-1:0]    onehot_i,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o,
  output logic            onehot_ok_o
);

  // Encode and classify the grant vector.
  always_comb begin
    idx_o       = onehot_to_idx(onehot_i);
    valid_o     = |onehot_i;
    onehot_ok_o = is_onehot(onehot_i);
  end

endmodule

// File: rtl/arb_requester.sv
// Requester-side companion to a fixed-priority one-hot arbiter.
// Request strobes are latched into pending bits and offered to the arbiter
// while IDLE; a legal grant starts an ownership tenure of HOLD_CYCLES
// cycles, after which the owner's pending bit is retired. Illegal grants
// set a sticky error flag.
// Handshake: in IDLE req mirrors pending and the arbiter answers with a
// same-cycle one-hot gnt; a legal gnt is accepted at the next rising edge.
// In OWN req is 0 and gnt is expected to be 0.
module arb_requester
  import arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    src_pulse,
  output logic [N-1:0]    req,
  input  logic [N-1:0]    gnt,
  output logic            owner_valid,
  output logic [IDXW-1:0] owner_idx,
  output logic            done_pulse,
  output logic [N-1:0]    pending,
  output logic            drop_pulse,
  output logic            gnt_err,
  input  logic            err_clr,
  output logic            state_dbg
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    clr_mask;
  logic            err_q, err_d, err_set;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_any, gnt_ok, legal;

  onehot_encoder u_enc (
    .onehot_i    (gnt),
    .idx_o       (gnt_idx),
    .valid_o     (gnt_any),
    .onehot_ok_o (gnt_ok)
  );

  // In IDLE req equals pend_q, so the request check uses pend_q directly.
  assign legal = gnt_ok && ((gnt & ~pend_q) == '0);

  // Next-state, tenure counter, owner capture, pending and error update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    err_set     = 1'b0;
    req         = '0;
    owner_valid = 1'b0;
    done_pulse  = 1'b0;
    clr_mask    = '0;
    case (state_q)
      IDLE: begin
        req = pend_q;
        if (pend_q != '0) begin
          if (legal) begin
            state_d = OWN;
            idx_d   = gnt_idx;
            cnt_d   = CW'(HOLD_CYCLES - 1);
          end else begin
            err_set = 1'b1;
          end
        end else if (gnt_any) begin
          err_set = 1'b1;
        end
      end
      OWN: begin
        owner_valid = 1'b1;
        if (gnt_any) err_set = 1'b1;
        if (cnt_q == '0) begin
          done_pulse = 1'b1;
          clr_mask   = N'(1) << idx_q;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A new strobe wins over the retiring clear, re-queuing that source.
    pend_d = (pend_q & ~clr_mask) | src_pulse;
    // A fresh error wins over a same-cycle clear.
    err_d  = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign owner_idx  = owner_valid ? idx_q : '0;
  assign pending    = pend_q;
  assign drop_pulse = |(src_pulse & pend_q & ~clr_mask);
  assign gnt_err    = err_q;
  assign state_dbg  = (state_q == OWN);

endmodule
